tick_irq_ctrl: RTL and testbench
================================

Name: tick_irq_ctrl

Overview:
- Consumes one-clk-period event ticks arriving from the clock-domain synchronizer stage and turns them into a CPU interrupt request.
- Keeps a saturating count of pending events and a sticky overflow flag.
- Drives a level IRQ with a forced low holdoff after each acknowledge, so the Z8S180 interrupt input sees a fresh assertion for each remaining event.
- Sits between the synchronizer output and the CPU interrupt/IO-register glue.

Parameters:
- CNT_BITS, 8, width of the pending-event counter; saturates at 2^CNT_BITS-1.
- HOLDOFF, 2, number of clk cycles irq is held low after an accepted ack; must be >= 1.

Ports:
- clk  input  1  sole clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-clk event pulse, already in the clk domain.
- en  input  1  interrupt/count enable.
- ack  input  1  one-clk strobe: consume one pending event.
- clr  input  1  one-clk strobe: discard all pending events and clear overflow.
- count  output  CNT_BITS  pending-event count (registered).
- irq  output  1  active-high interrupt request.
- overflow  output  1  sticky: a tick arrived while count was saturated.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset sampled high at a posedge:
  - count=0, overflow=0, state=IDLE, holdoff counter=0, irq=0.
  - Reset overrides all other inputs; reset mid-operation discards pending events and any holdoff in progress.
- FSM has three states:
  - IDLE: irq=0.
  - ASSERT: irq=1.
  - HOLD: irq=0.
  - irq is decoded from the state register only (no combinational path from inputs).
- Input priority at each edge: reset > clr > en=0 > tick/ack.
- clr=1:
  - count<=0, overflow<=0, state<=IDLE.
  - Same-cycle tick and ack are dropped.
- en=0 (no clr):
  - Ticks are ignored (not counted); ack is ignored.
  - count and overflow are retained; state<=IDLE.
- en=1 count update:
  - inc = tick.
  - dec = ack accepted, which requires state==ASSERT; ack in IDLE or HOLD is ignored.
  - inc and dec together: count unchanged.
  - inc alone with count<max: count+1.
  - inc alone with count==max: count stays at max, overflow<=1.
  - dec alone: count-1 (never below 0, since ASSERT implies count>=1).
- Transitions (en=1, no clr), where cn is the next count value:
  - IDLE -> ASSERT when cn!=0, including en rising while count!=0.
  - ASSERT -> HOLD on accepted ack; holdoff counter loaded with HOLDOFF-1.
  - ASSERT stays in ASSERT otherwise.
  - HOLD: counter decrements each cycle. When it is 0, go to ASSERT if cn!=0, else IDLE.
  - HOLD: ticks are still counted during holdoff.
- Resulting timing:
  - Tick sampled at edge k: count=1 and irq=1 from edge k onward (1-cycle latency from the tick cycle).
  - Ack accepted at edge k: irq low for exactly HOLDOFF cycles, then re-asserts if events remain.
- overflow is cleared only by clr or reset. count is never modified by overflow.

Test Plan:
- Reset, then single tick with en=1 -> count=1 and irq=1 one edge after the tick; ack -> count=0, irq=0, stays in IDLE after HOLDOFF=2 cycles.
- 3 ticks, then ack with HOLDOFF=2 -> count 3→2, irq low for exactly 2 cycles then high; repeat acks until count=0 and irq stays low.
- CNT_BITS=2, 5 ticks -> count saturates at 3, overflow=1; ack -> count=2 and overflow still 1; clr -> count=0, overflow=0, irq=0.
- Simultaneous events:
  - tick+ack in ASSERT with count=2 -> count stays 2, irq enters HOLD.
  - tick+clr -> count=0.
  - ack in HOLD -> ignored, count unchanged.
- en=0 with count=2: irq=0, ticks not counted, count holds 2; raise en -> irq=1 on the next edge.
- Reset asserted during HOLD with count=4 -> next edge count=0, overflow=0, irq=0; a tick after reset release -> count=1, irq=1.

Source files
------------

// File: rtl/tick_irq_ctrl_if.sv
// Event-tick / interrupt bundle between the synchronizer, the tick_irq_ctrl
// block and the CPU interrupt glue. dbg_state mirrors the controller FSM.
interface tick_irq_ctrl_if #(
    parameter int CNT_BITS = 8
);
    logic                tick;
    logic                en;
    logic                ack;
    logic                clr;
    logic [CNT_BITS-1:0] count;
    logic                irq;
    logic                overflow;
    logic [1:0]          dbg_state;

    // Strobes (tick/ack/clr) are single-cycle pulses sampled on posedge clk;
    // there is no ready back-pressure: an ack outside ASSERT is simply dropped.
    modport master (
        output tick, en, ack, clr,
        input  count, irq, overflow, dbg_state
    );

    modport slave (
        input  tick, en, ack, clr,
        output count, irq, overflow, dbg_state
    );
endinterface

// File: rtl/tick_irq_ctrl.sv
// Pending-event counter with a level IRQ that drops for HOLDOFF cycles after
// each accepted ack, so the CPU sees a fresh edge for every remaining event.
module tick_irq_ctrl #(
    parameter int CNT_BITS = 8,
    parameter int HOLDOFF  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    tick_irq_ctrl_if.slave         bus
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [HW-1:0]       HOLD_LD  = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                ack_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // An ack only consumes an event while the request is actually raised.
    assign ack_acc = bus.ack && (state_q == ASSERT);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (bus.clr) begin
            state_d = IDLE;
            hold_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (!bus.en) begin
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            if (bus.tick && !ack_acc) begin
                if (count_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (ack_acc && !bus.tick) begin
                count_d = count_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (count_d != '0) begin
                        state_d = ASSERT;
                    end
                end
                ASSERT: begin
                    if (ack_acc) begin
                        state_d = HOLD;
                        hold_d  = HOLD_LD;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) begin
                        state_d = (count_d != '0) ? ASSERT : IDLE;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign bus.count     = count_q;
    assign bus.irq       = (state_q == ASSERT);
    assign bus.overflow  = ovf_q;
    assign bus.dbg_state = state_q;

    // Being in ASSERT always means at least one event is pending.
    assert property (@(posedge clk) disable iff (reset)
        (state_q == ASSERT) |-> (count_q != '0));

endmodule

// File: tb/tb_tick_irq_ctrl.sv
// Directed bench for tick_irq_ctrl: a default 8-bit instance plus a 2-bit
// instance for the saturation/overflow cases.
module tb_tick_irq_ctrl;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ASSERT = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [31:0] exp_q[$];

    tick_irq_ctrl_if #(.CNT_BITS(8)) bus ();
    tick_irq_ctrl_if #(.CNT_BITS(2)) sbus ();

    tick_irq_ctrl #(.CNT_BITS(8), .HOLDOFF(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    tick_irq_ctrl #(.CNT_BITS(2), .HOLDOFF(2)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drivers: inputs change 1 time unit after the edge, checks happen there too.
    task automatic pulse(input logic t, input logic a, input logic c);
        bus.tick = t;
        bus.ack  = a;
        bus.clr  = c;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        bus.ack  = 1'b0;
        bus.clr  = 1'b0;
    endtask

    task automatic spulse(input logic t, input logic a, input logic c);
        sbus.tick = t;
        sbus.ack  = a;
        sbus.clr  = c;
        @(posedge clk);
        #1;
        sbus.tick = 1'b0;
        sbus.ack  = 1'b0;
        sbus.clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.tick = 1'b0;  bus.en = 1'b0;  bus.ack = 1'b0;  bus.clr = 1'b0;
        sbus.tick = 1'b0; sbus.en = 1'b0; sbus.ack = 1'b0; sbus.clr = 1'b0;
        idle(2);
        check("rst_count", 32'(bus.count), 0);
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
        reset = 1'b0;

        // Single tick, single ack
        bus.en = 1'b1;
        idle(1);
        check("en_no_evt_irq", 32'(bus.irq), 0);
        pulse(1'b1, 1'b0, 1'b0);
        check("t1_count", 32'(bus.count), 1);
        check("t1_irq", 32'(bus.irq), 1);
        pulse(1'b0, 1'b1, 1'b0);
        check("t1_ack_count", 32'(bus.count), 0);
        check("t1_ack_irq", 32'(bus.irq), 0);
        check("t1_ack_state", 32'(bus.dbg_state), 32'(S_HOLD));
        idle(2);
        check("t1_end_state", 32'(bus.dbg_state), 32'(S_IDLE));
        check("t1_end_irq", 32'(bus.irq), 0);

        // Three ticks, holdoff timing
        repeat (3) pulse(1'b1, 1'b0, 1'b0);
        check("t3_count", 32'(bus.count), 3);
        pulse(1'b0, 1'b1, 1'b0);
        check("t3_ack_count", 32'(bus.count), 2);
        check("t3_hold_irq0", 32'(bus.irq), 0);
        idle(1);
        check("t3_hold_irq1", 32'(bus.irq), 0);
        idle(1);
        check("t3_reassert", 32'(bus.irq), 1);
        exp_q.push_back(1);
        exp_q.push_back(0);
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            pulse(1'b0, 1'b1, 1'b0);
            check("t3_drain_count", 32'(bus.count), e);
            check("t3_drain_irq", 32'(bus.irq), 0);
            idle(2);
            check("t3_after_hold", 32'(bus.irq), (e != 0) ? 1 : 0);
        end
        idle(2);
        check("t3_stay_low", 32'(bus.irq), 0);

        // Tick during holdoff is counted and re-raises irq
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("hold_tick_count", 32'(bus.count), 1);
        check("hold_tick_state", 32'(bus.dbg_state), 32'(S_HOLD));
        idle(1);
        check("hold_tick_irq", 32'(bus.irq), 1);
        pulse(1'b0, 1'b1, 1'b0);
        idle(2);

        // Simultaneous events
        repeat (2) pulse(1'b1, 1'b0, 1'b0);
        check("sim_pre_count", 32'(bus.count), 2);
        pulse(1'b1, 1'b1, 1'b0);
        check("sim_tick_ack_count", 32'(bus.count), 2);
        check("sim_tick_ack_state", 32'(bus.dbg_state), 32'(S_HOLD));
        pulse(1'b0, 1'b1, 1'b0);
        check("sim_ack_in_hold", 32'(bus.count), 2);
        idle(1);
        check("sim_reassert", 32'(bus.irq), 1);
        pulse(1'b1, 1'b0, 1'b1);
        check("sim_tick_clr_count", 32'(bus.count), 0);
        check("sim_tick_clr_irq", 32'(bus.irq), 0);

        // Enable gating
        repeat (2) pulse(1'b1, 1'b0, 1'b0);
        check("en_pre_irq", 32'(bus.irq), 1);
        bus.en = 1'b0;
        idle(1);
        check("en0_irq", 32'(bus.irq), 0);
        check("en0_count", 32'(bus.count), 2);
        pulse(1'b1, 1'b0, 1'b0);
        check("en0_tick_ignored", 32'(bus.count), 2);
        pulse(1'b0, 1'b1, 1'b0);
        check("en0_ack_ignored", 32'(bus.count), 2);
        bus.en = 1'b1;
        idle(1);
        check("en1_irq", 32'(bus.irq), 1);

        // Reset during holdoff
        repeat (3) pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check("rh_count", 32'(bus.count), 4);
        check("rh_state", 32'(bus.dbg_state), 32'(S_HOLD));
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rh_rst_count", 32'(bus.count), 0);
        check("rh_rst_ovf", 32'(bus.overflow), 0);
        check("rh_rst_irq", 32'(bus.irq), 0);
        pulse(1'b1, 1'b0, 1'b0);
        check("rh_tick_count", 32'(bus.count), 1);
        check("rh_tick_irq", 32'(bus.irq), 1);
        check("main_ovf_never", 32'(bus.overflow), 0);

        // Saturation on the 2-bit instance
        sbus.en = 1'b1;
        repeat (3) spulse(1'b1, 1'b0, 1'b0);
        check("sat_at_max", 32'(sbus.count), 3);
        check("sat_no_ovf_yet", 32'(sbus.overflow), 0);
        repeat (2) spulse(1'b1, 1'b0, 1'b0);
        check("sat_count", 32'(sbus.count), 3);
        check("sat_ovf", 32'(sbus.overflow), 1);
        spulse(1'b0, 1'b1, 1'b0);
        check("sat_ack_count", 32'(sbus.count), 2);
        check("sat_ack_ovf", 32'(sbus.overflow), 1);
        spulse(1'b0, 1'b0, 1'b1);
        check("sat_clr_count", 32'(sbus.count), 0);
        check("sat_clr_ovf", 32'(sbus.overflow), 0);
        check("sat_clr_irq", 32'(sbus.irq), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
